// File: rtl/scan_bus_bridge.sv
// scan_bus_bridge: turns scan-chain commands into single-word register/SRAM bus
// transactions and returns read data and completion status to the scan capture fields.
module scan_bus_bridge #(
  parameter int                ADDR_W      = 20,
  parameter int                DATA_W      = 32,
  parameter int                TIMEOUT     = 64,
  parameter logic [DATA_W-1:0] TIMEOUT_PAT = 32'hDEAD_0BAD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scan_id,
  input  logic              scan_wen,
  input  logic              scan_ren,
  input  logic [ADDR_W-1:0] scan_addr,
  input  logic [DATA_W-1:0] scan_wdata,
  output logic [DATA_W-1:0] scan_rdata,
  output logic              scan_ready,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              busy
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic              s1, s2, s3;
  logic              cmd_evt;
  logic              take;
  logic [1:0]        state;
  logic              pend;
  logic              overrun;
  logic              op_we;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;
  logic [CNT_W-1:0]  wait_cnt;
  logic              fin;
  logic              fin_to;
  logic              unused_overrun;

  assign cmd_evt = s2 ^ s3;
  assign take    = (state == IDLE) && (cmd_evt || pend);
  assign busy    = (state != IDLE);

  // overrun is debug-only state with no output port
  assign unused_overrun = overrun;

  // scan_id synchronizer and edge register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= scan_id;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // One-deep event holding; in IDLE a held event is served first and a
  // simultaneous fresh one takes its place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend    <= 1'b0;
      overrun <= 1'b0;
    end else if (state == IDLE) begin
      pend <= cmd_evt & pend;
    end else if (cmd_evt) begin
      if (pend) overrun <= 1'b1;
      else      pend    <= 1'b1;
    end
  end

  // Command fields: quasi-static scan values sampled on acceptance only
  always_ff @(posedge clk) begin
    if (take) begin
      op_we    <= scan_wen;
      op_addr  <= scan_addr;
      op_wdata <= scan_wdata;
    end
  end

  // Transaction sequencing; fin marks an ack or timeout seen last cycle so
  // bus_req drops one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      scan_rdata <= '0;
      scan_ready <= 1'b0;
      wait_cnt   <= '0;
      fin        <= 1'b0;
      fin_to     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            scan_ready <= 1'b0;
            wait_cnt   <= '0;
            fin        <= 1'b0;
            fin_to     <= 1'b0;
            state      <= (scan_wen || scan_ren) ? ISSUE : DONE;
          end
        end
        ISSUE: begin
          bus_req   <= 1'b1;
          bus_we    <= op_we;
          bus_addr  <= op_addr;
          bus_wdata <= op_wdata;
          state     <= WAIT;
        end
        WAIT: begin
          if (fin) begin
            bus_req <= 1'b0;
            if (fin_to) scan_rdata <= TIMEOUT_PAT;
            state <= DONE;
          end else if (bus_ack) begin
            if (!op_we) scan_rdata <= bus_rdata;
            fin <= 1'b1;
          end else if (wait_cnt == CNT_LAST) begin
            fin    <= 1'b1;
            fin_to <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          scan_ready <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_bus_bridge.sv
// Bench for scan_bus_bridge: transaction-level model with a per-cycle compare
// process, plus directed commands with hand-computed literal expectations.
module tb_scan_bus_bridge;

  localparam int          TIMEOUT = 64;
  localparam logic [31:0] PAT     = 32'hDEAD_0BAD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scan_id = 1'b0;
  logic        scan_wen = 1'b0;
  logic        scan_ren = 1'b0;
  logic [19:0] scan_addr = '0;
  logic [31:0] scan_wdata = '0;
  logic [31:0] scan_rdata;
  logic        scan_ready;
  logic        bus_req;
  logic        bus_we;
  logic [19:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        busy;

  scan_bus_bridge #(
    .ADDR_W(20), .DATA_W(32), .TIMEOUT(TIMEOUT), .TIMEOUT_PAT(PAT)
  ) dut (
    .clk(clk), .rst(rst), .scan_id(scan_id), .scan_wen(scan_wen),
    .scan_ren(scan_ren), .scan_addr(scan_addr), .scan_wdata(scan_wdata),
    .scan_rdata(scan_rdata), .scan_ready(scan_ready), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [19:0] addr;
    logic [31:0] wdata;
    int          width;
  } txn_t;

  int          errors = 0;
  int          checks = 0;
  txn_t        txn_q[$];
  logic [31:0] res_q[$];
  logic [31:0] model_rdata = '0;

  int          ack_delay = 0;
  bit          never_ack = 1'b0;
  bit          stray_ack = 1'b0;
  logic [31:0] rd_value = '0;

  bit          mon_en = 1'b0;
  int          done_cnt = 0;
  int          txn_cnt = 0;
  logic        last_we = 1'b0;
  logic [19:0] last_addr = '0;
  int          last_width = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Issue one command: set fields, record what the spec says must happen, toggle scan_id.
  task automatic start_cmd(input bit wen, input bit ren, input logic [19:0] a,
                           input logic [31:0] wd, input int d, input bit nev,
                           input logic [31:0] rv);
    logic [31:0] res;
    scan_wen   = wen;
    scan_ren   = ren;
    scan_addr  = a;
    scan_wdata = wd;
    ack_delay  = d;
    never_ack  = nev;
    rd_value   = rv;
    if (wen || ren)
      txn_q.push_back('{we: wen, addr: a, wdata: wd, width: nev ? TIMEOUT + 1 : d + 2});
    if (!wen && ren) res = nev ? PAT : rv;
    else             res = model_rdata;
    model_rdata = res;
    res_q.push_back(res);
    scan_id = ~scan_id;
  endtask

  task automatic wait_done(input int target, input string name);
    int k = 0;
    while (done_cnt < target && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk(name, 64'(done_cnt >= target), 64'(1));
  endtask

  // Bus responder: ack d cycles into the request, optional stray acks while idle
  initial begin : bus_model
    int rc;
    bit acked;
    rc = 0;
    acked = 1'b0;
    forever begin
      @(negedge clk);
      bus_ack = 1'b0;
      if (!bus_req) begin
        rc = 0;
        acked = 1'b0;
        if (stray_ack) bus_ack = 1'b1;
      end else begin
        if (!acked && !never_ack && rc == ack_delay) begin
          bus_ack   = 1'b1;
          bus_rdata = rd_value;
          acked     = 1'b1;
        end
        rc++;
      end
    end
  end

  // Per-cycle compare against the transaction model
  initial begin : monitor
    bit          in_req;
    bit          bogus;
    bit          pb;
    bit          hold_v;
    logic [31:0] hold;
    logic [31:0] e;
    txn_t        cur;
    int          w;
    in_req = 0; bogus = 0; pb = 0; hold_v = 0; hold = '0; w = 0;
    cur = '{we: 1'b0, addr: '0, wdata: '0, width: 0};
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        in_req = 0;
        pb     = 0;
        hold_v = 0;
      end else begin
        if (bus_req) begin
          if (!in_req) begin
            in_req = 1;
            w = 0;
            bogus = (txn_q.size() == 0);
            if (bogus) begin
              checks++;
              errors++;
              $display("FAIL unexpected_req: bus_req high at addr %0h, required no request", bus_addr);
            end else begin
              cur = txn_q[0];
            end
          end
          w++;
          last_we   = bus_we;
          last_addr = bus_addr;
          if (!bogus) begin
            chk("bus_we", 64'(bus_we), 64'(cur.we));
            chk("bus_addr", 64'(bus_addr), 64'(cur.addr));
            if (cur.we) chk("bus_wdata", 64'(bus_wdata), 64'(cur.wdata));
          end
        end else if (in_req) begin
          in_req = 0;
          last_width = w;
          txn_cnt++;
          if (!bogus) begin
            chk("req_width", 64'(w), 64'(cur.width));
            void'(txn_q.pop_front());
          end
        end
        if (busy) chk("ready_while_busy", 64'(scan_ready), 64'(0));
        if (pb && !busy) begin
          done_cnt++;
          if (res_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: busy fell, required no command in flight");
          end else begin
            e = res_q.pop_front();
            chk("done_ready", 64'(scan_ready), 64'(1));
            chk("done_rdata", 64'(scan_rdata), 64'(e));
            hold = e;
            hold_v = 1;
          end
        end else if (!busy && hold_v) begin
          chk("hold_rdata", 64'(scan_rdata), 64'(hold));
          chk("hold_ready", 64'(scan_ready), 64'(1));
        end
        pb = busy;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: run still active at 500us, required to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int base;
    int tbase;
    int k;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bus_req", 64'(bus_req), 64'(0));
    chk("rst_bus_we", 64'(bus_we), 64'(0));
    chk("rst_bus_addr", 64'(bus_addr), 64'(0));
    chk("rst_bus_wdata", 64'(bus_wdata), 64'(0));
    chk("rst_scan_rdata", 64'(scan_rdata), 64'(0));
    chk("rst_scan_ready", 64'(scan_ready), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", 64'(busy), 64'(0));

    // Read with same-cycle ack, cycle-exact latency from E
    @(negedge clk);
    start_cmd(1'b0, 1'b1, 20'h00600, 32'h0, 0, 1'b0, 32'h7);
    @(posedge clk);             // E
    @(posedge clk); #1;         // E+1
    chk("rd_busy_e1", 64'(busy), 64'(0));
    @(posedge clk); #1;         // E+2
    chk("rd_busy_e2", 64'(busy), 64'(1));
    chk("rd_req_e2", 64'(bus_req), 64'(0));
    @(posedge clk); #1;         // E+3
    chk("rd_req_e3", 64'(bus_req), 64'(1));
    @(posedge clk);
    @(posedge clk); #1;         // E+5
    chk("rd_ready_e5", 64'(scan_ready), 64'(0));
    @(posedge clk); #1;         // E+6
    chk("rd_ready_e6", 64'(scan_ready), 64'(1));
    chk("rd_rdata_e6", 64'(scan_rdata), 64'(32'h0000_0007));
    wait_done(1, "rd_done");

    // Write, ack two cycles into the wait
    tbase = txn_cnt;
    repeat (2) @(negedge clk);
    start_cmd(1'b1, 1'b0, 20'h00480, 32'h1, 2, 1'b0, 32'h0);
    wait_done(2, "wr_done");
    chk("wr_pulses", 64'(txn_cnt - tbase), 64'(1));
    chk("wr_we", 64'(last_we), 64'(1));
    chk("wr_width", 64'(last_width), 64'(4));
    chk("wr_rdata_kept", 64'(scan_rdata), 64'(32'h7));

    // NOP with stray acks on an idle bus
    tbase = txn_cnt;
    stray_ack = 1'b1;
    repeat (2) @(negedge clk);
    start_cmd(1'b0, 1'b0, 20'h00333, 32'h0, 0, 1'b0, 32'h0);
    wait_done(3, "nop_done");
    repeat (3) @(negedge clk);
    chk("nop_pulses", 64'(txn_cnt - tbase), 64'(0));
    chk("nop_ready", 64'(scan_ready), 64'(1));
    chk("nop_rdata", 64'(scan_rdata), 64'(32'h7));

    // Write wins when both requests are set
    start_cmd(1'b1, 1'b1, 20'h00ABC, 32'hCAFE_F00D, 1, 1'b0, 32'h1234);
    wait_done(4, "prio_done");
    stray_ack = 1'b0;
    chk("prio_we", 64'(last_we), 64'(1));
    chk("prio_addr", 64'(last_addr), 64'(20'h00ABC));
    chk("prio_rdata", 64'(scan_rdata), 64'(32'h7));

    // Timeout
    repeat (2) @(negedge clk);
    start_cmd(1'b0, 1'b1, 20'd1023, 32'h0, 0, 1'b1, 32'h0);
    wait_done(5, "to_done");
    chk("to_width", 64'(last_width), 64'(TIMEOUT + 1));
    chk("to_rdata", 64'(scan_rdata), 64'(32'hDEAD_0BAD));
    chk("to_ready", 64'(scan_ready), 64'(1));

    // Pending event plus a dropped third toggle
    never_ack = 1'b0;
    base  = done_cnt;
    tbase = txn_cnt;
    repeat (2) @(negedge clk);
    start_cmd(1'b1, 1'b0, 20'd0, 32'h0000_00A0, 5, 1'b0, 32'h0);
    repeat (3) @(negedge clk);
    start_cmd(1'b0, 1'b1, 20'd1, 32'h0, 5, 1'b0, 32'h0000_00B1);
    repeat (3) @(negedge clk);
    scan_id = ~scan_id;
    wait_done(base + 2, "pend_done");
    repeat (20) @(negedge clk);
    chk("pend_cmds", 64'(done_cnt - base), 64'(2));
    chk("pend_pulses", 64'(txn_cnt - tbase), 64'(2));
    chk("pend_last_addr", 64'(last_addr), 64'(20'd1));
    chk("pend_rdata", 64'(scan_rdata), 64'(32'h0000_00B1));

    // Reset in the middle of a wait
    @(negedge clk);
    start_cmd(1'b0, 1'b1, 20'h00777, 32'h0, 0, 1'b1, 32'h0);
    k = 0;
    while (!bus_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("mid_req_seen", 64'(bus_req), 64'(1));
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_req", 64'(bus_req), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_ready", 64'(scan_ready), 64'(0));
    chk("mid_rst_rdata", 64'(scan_rdata), 64'(0));
    scan_id = 1'b0;
    never_ack = 1'b0;
    txn_q.delete();
    res_q.delete();
    model_rdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'(0));
    chk("post_rst_req", 64'(bus_req), 64'(0));
    base = done_cnt;
    start_cmd(1'b0, 1'b1, 20'h00123, 32'h0, 1, 1'b0, 32'h0000_55AA);
    wait_done(base + 1, "post_rst_done");
    chk("post_rst_rdata", 64'(scan_rdata), 64'(32'h0000_55AA));
    chk("post_rst_addr", 64'(last_addr), 64'(20'h00123));
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
